mem_arbiter: RTL and testbench

Round-robin arbiter that lets NUM_MASTERS requesters (CPU fetch/data ports, DMA, debug) share the single mmu memory-request port. Each master sees the same enable/width/address/data/ready handshake the mmu exposes; the arbiter registers one request at a time, forwards it to the mmu, and routes the response back to the owner. It adds fair arbitration and a response timeout with an error flag.

---
 rtl/mem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Round-robin arbiter that lets NUM_MASTERS requesters share one mmu request
// port. It takes one request at a time, forwards it to the mmu from
// registers, and returns the response (or a timeout error) to the owner.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   m_write_enable    [NUM_MASTERS]             per-master write request
//   m_read_enable     [NUM_MASTERS]             per-master read request
//   m_signed_read     [NUM_MASTERS]             per-master sign-extend flag
//   m_data_width      [2*NUM_MASTERS]           per-master width code
//   m_address         [ADDR_WIDTH*NUM_MASTERS]  per-master byte address
//   m_data_in         [DATA_WIDTH*NUM_MASTERS]  per-master write data
//   m_data_out        [DATA_WIDTH]              shared read data, valid with m_mem_ready
//   m_mem_ready       [NUM_MASTERS]             one-cycle completion pulse to owner
//   m_error           [NUM_MASTERS]             one-cycle timeout pulse to owner
//   s_*               single request port to the mmu
//   s_data_out, s_mem_ready  mmu response
module mem_arbiter #(
   parameter int NUM_MASTERS    = 2,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_MASTERS-1:0]            m_write_enable,
   input  logic [NUM_MASTERS-1:0]            m_read_enable,
   input  logic [NUM_MASTERS-1:0]            m_signed_read,
   input  logic [2*NUM_MASTERS-1:0]          m_data_width,
   input  logic [ADDR_WIDTH*NUM_MASTERS-1:0] m_address,
   input  logic [DATA_WIDTH*NUM_MASTERS-1:0] m_data_in,
   output logic [DATA_WIDTH-1:0]             m_data_out,
   output logic [NUM_MASTERS-1:0]            m_mem_ready,
   output logic [NUM_MASTERS-1:0]            m_error,
   output logic                              s_write_enable,
   output logic                              s_read_enable,
   output logic                              s_signed_read,
   output logic [1:0]                        s_data_width,
   output logic [ADDR_WIDTH-1:0]             s_address,
   output logic [DATA_WIDTH-1:0]             s_data_in,
   input  logic [DATA_WIDTH-1:0]             s_data_out,
   input  logic                              s_mem_ready
);

   localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [IDX_W:0]         NUM_M_L      = (IDX_W+1)'(NUM_MASTERS);
   localparam logic [IDX_W-1:0]       LAST_RST_L   = IDX_W'(NUM_MASTERS-1);
   localparam logic [CNT_W-1:0]       CNT_LAST_L   = CNT_W'(TIMEOUT_CYCLES-1);
   localparam logic [NUM_MASTERS-1:0] ONE_HOT_0_L  = NUM_MASTERS'(1);
   localparam bit                     TIMEOUT_EN_L = (TIMEOUT_CYCLES != 0);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;
   localparam logic [1:0] ST_REL  = 2'd3;

   logic [1:0]             state_r;
   logic [IDX_W-1:0]       owner_r;
   logic [IDX_W-1:0]       last_r;
   logic [CNT_W-1:0]       cnt_r;
   logic [DATA_WIDTH-1:0]  data_out_r;
   logic [NUM_MASTERS-1:0] mem_ready_r;
   logic [NUM_MASTERS-1:0] error_r;
   logic                   s_we_r;
   logic                   s_re_r;
   logic                   s_sgn_r;
   logic [1:0]             s_width_r;
   logic [ADDR_WIDTH-1:0]  s_addr_r;
   logic [DATA_WIDTH-1:0]  s_wdata_r;

   logic [NUM_MASTERS-1:0] req_s;
   logic                   grant_found_s;
   logic [IDX_W-1:0]       grant_idx_s;
   logic                   timeout_hit_s;

   logic [1:0]             width_a_s [NUM_MASTERS];
   logic [ADDR_WIDTH-1:0]  addr_a_s  [NUM_MASTERS];
   logic [DATA_WIDTH-1:0]  wdata_a_s [NUM_MASTERS];

   for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
      assign width_a_s[gi] = m_data_width[2*gi +: 2];
      assign addr_a_s[gi]  = m_address[ADDR_WIDTH*gi +: ADDR_WIDTH];
      assign wdata_a_s[gi] = m_data_in[DATA_WIDTH*gi +: DATA_WIDTH];
   end

   assign req_s = m_write_enable | m_read_enable;

   // The counter holds the number of BUSY cycles already completed, so the
   // last allowed BUSY cycle is the one where it equals TIMEOUT_CYCLES-1.
   assign timeout_hit_s = TIMEOUT_EN_L && (cnt_r == CNT_LAST_L);

   // Round-robin pick: first requester scanning upward from last_r+1 with wrap.
   always_comb begin : arb_comb
      logic [IDX_W:0]   sum_v;
      logic [IDX_W-1:0] cand_v;
      logic             hit_v;
      grant_found_s = 1'b0;
      grant_idx_s   = '0;
      sum_v         = '0;
      cand_v        = '0;
      hit_v         = 1'b0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         sum_v         = {1'b0, last_r} + (IDX_W+1)'(k);
         sum_v         = (sum_v >= NUM_M_L) ? (sum_v - NUM_M_L) : sum_v;
         cand_v        = sum_v[IDX_W-1:0];
         hit_v         = req_s[cand_v] & ~grant_found_s;
         grant_idx_s   = hit_v ? cand_v : grant_idx_s;
         grant_found_s = grant_found_s | hit_v;
      end
   end

   // Transaction FSM and all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         owner_r     <= '0;
         last_r      <= LAST_RST_L;
         cnt_r       <= '0;
         data_out_r  <= '0;
         mem_ready_r <= '0;
         error_r     <= '0;
         s_we_r      <= 1'b0;
         s_re_r      <= 1'b0;
         s_sgn_r     <= 1'b0;
         s_width_r   <= 2'b00;
         s_addr_r    <= '0;
         s_wdata_r   <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (grant_found_s) begin
                  owner_r   <= grant_idx_s;
                  // A write wins when both enables are set.
                  s_we_r    <= m_write_enable[grant_idx_s];
                  s_re_r    <= m_read_enable[grant_idx_s] & ~m_write_enable[grant_idx_s];
                  s_sgn_r   <= m_signed_read[grant_idx_s];
                  s_width_r <= width_a_s[grant_idx_s];
                  s_addr_r  <= addr_a_s[grant_idx_s];
                  s_wdata_r <= wdata_a_s[grant_idx_s];
                  cnt_r     <= '0;
                  state_r   <= ST_BUSY;
               end else begin
                  state_r   <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               // A late mmu completion beats a timeout in the same cycle.
               if (s_mem_ready || timeout_hit_s) begin
                  data_out_r  <= s_mem_ready ? s_data_out : '0;
                  mem_ready_r <= ONE_HOT_0_L << owner_r;
                  error_r     <= s_mem_ready ? '0 : (ONE_HOT_0_L << owner_r);
                  s_we_r      <= 1'b0;
                  s_re_r      <= 1'b0;
                  s_sgn_r     <= 1'b0;
                  s_width_r   <= 2'b00;
                  s_addr_r    <= '0;
                  s_wdata_r   <= '0;
                  last_r      <= owner_r;
                  cnt_r       <= '0;
                  state_r     <= ST_RESP;
               end else begin
                  cnt_r       <= cnt_r + CNT_W'(1);
                  state_r     <= ST_BUSY;
               end
            end
            ST_RESP: begin
               data_out_r  <= '0;
               mem_ready_r <= '0;
               error_r     <= '0;
               state_r     <= ST_REL;
            end
            ST_REL: begin
               // Quiet cycle so the owner can drop its request before the next scan.
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign m_data_out     = data_out_r;
   assign m_mem_ready    = mem_ready_r;
   assign m_error        = error_r;
   assign s_write_enable = s_we_r;
   assign s_read_enable  = s_re_r;
   assign s_signed_read  = s_sgn_r;
   assign s_data_width   = s_width_r;
   assign s_address      = s_addr_r;
   assign s_data_in      = s_wdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter (4 masters, timeout of 8 cycles).
// Stimulus pushes expected mmu-side requests and master-side responses into
// queues; independent monitors pop and compare when the DUT presents them.
module tb_mem_arbiter;

   localparam int NM = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic             clk;
   logic             reset;
   logic [NM-1:0]    m_write_enable;
   logic [NM-1:0]    m_read_enable;
   logic [NM-1:0]    m_signed_read;
   logic [2*NM-1:0]  m_data_width;
   logic [AW*NM-1:0] m_address;
   logic [DW*NM-1:0] m_data_in;
   logic [DW-1:0]    m_data_out;
   logic [NM-1:0]    m_mem_ready;
   logic [NM-1:0]    m_error;
   logic             s_write_enable;
   logic             s_read_enable;
   logic             s_signed_read;
   logic [1:0]       s_data_width;
   logic [AW-1:0]    s_address;
   logic [DW-1:0]    s_data_in;
   logic [DW-1:0]    s_data_out;
   logic             s_mem_ready;

   mem_arbiter #(
      .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(reset),
      .m_write_enable(m_write_enable), .m_read_enable(m_read_enable),
      .m_signed_read(m_signed_read), .m_data_width(m_data_width),
      .m_address(m_address), .m_data_in(m_data_in),
      .m_data_out(m_data_out), .m_mem_ready(m_mem_ready), .m_error(m_error),
      .s_write_enable(s_write_enable), .s_read_enable(s_read_enable),
      .s_signed_read(s_signed_read), .s_data_width(s_data_width),
      .s_address(s_address), .s_data_in(s_data_in),
      .s_data_out(s_data_out), .s_mem_ready(s_mem_ready)
   );

   typedef struct { logic we; logic re; logic sg; logic [1:0] w; logic [31:0] a; logic [31:0] d; } mreq_t;
   typedef struct { int m; logic we; logic re; logic sg; logic [1:0] w; logic [31:0] a; logic [31:0] d; bit chk; } s_exp_t;
   typedef struct { int m; logic [31:0] d; logic err; int lat; int gap; } r_exp_t;
   typedef struct { int delay; logic [31:0] d; } mmu_t;

   mreq_t   mq [NM][$];
   s_exp_t  s_q[$];
   r_exp_t  r_q[$];
   mmu_t    mmu_q[$];

   logic [NM-1:0] active;
   logic [NM-1:0] done;
   int assert_cyc [NM];
   int cyc;
   int n_checks;
   int n_fail;
   int resp_seen;
   int s_start_cyc;
   int last_resp_cyc;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   task automatic enq_req(input int m, input logic we, input logic re, input logic sg,
                          input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
      mreq_t r;
      r.we = we; r.re = re; r.sg = sg; r.w = w; r.a = a; r.d = d;
      mq[m].push_back(r);
   endtask

   task automatic exp_s(input int m, input logic we, input logic re, input logic sg,
                        input logic [1:0] w, input logic [31:0] a, input logic [31:0] d, input bit chk);
      s_exp_t e;
      e.m = m; e.we = we; e.re = re; e.sg = sg; e.w = w; e.a = a; e.d = d; e.chk = chk;
      s_q.push_back(e);
   endtask

   task automatic exp_r(input int m, input logic [31:0] d, input logic err, input int lat, input int gap);
      r_exp_t e;
      e.m = m; e.d = d; e.err = err; e.lat = lat; e.gap = gap;
      r_q.push_back(e);
   endtask

   task automatic mmu(input int delay, input logic [31:0] d);
      mmu_t e;
      e.delay = delay; e.d = d;
      mmu_q.push_back(e);
   endtask

   task automatic wait_drain(input int max_cycles);
      int n;
      n = 0;
      while ((r_q.size() != 0 || s_q.size() != 0 || active != '0) && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      if (n >= max_cycles) fail_now("drain_timeout");
   endtask

   // Master agents: present queued requests, drop them the cycle after m_mem_ready.
   initial begin
      mreq_t r;
      m_write_enable = '0; m_read_enable = '0; m_signed_read = '0;
      m_data_width = '0; m_address = '0; m_data_in = '0;
      active = '0; done = '0;
      forever begin
         @(posedge clk); #1;
         if (reset) begin
            for (int i = 0; i < NM; i++) mq[i].delete();
            active = '0; done = '0;
            m_write_enable = '0; m_read_enable = '0;
         end else begin
            for (int i = 0; i < NM; i++) begin
               if (done[i]) begin
                  m_write_enable[i] = 1'b0;
                  m_read_enable[i]  = 1'b0;
                  done[i]   = 1'b0;
                  active[i] = 1'b0;
                  r = mq[i].pop_front();
               end else if (!active[i] && mq[i].size() != 0) begin
                  r = mq[i][0];
                  m_write_enable[i]     = r.we;
                  m_read_enable[i]      = r.re;
                  m_signed_read[i]      = r.sg;
                  m_data_width[2*i +: 2] = r.w;
                  m_address[AW*i +: AW] = r.a;
                  m_data_in[DW*i +: DW] = r.d;
                  active[i]     = 1'b1;
                  assert_cyc[i] = cyc;
               end
            end
         end
      end
   end

   // mmu model: completes the n-th BUSY cycle of each transaction (delay 0 = never).
   initial begin
      mmu_t cur;
      int busy;
      s_mem_ready = 1'b0; s_data_out = '0; busy = 0;
      cur.delay = 0; cur.d = '0;
      forever begin
         @(posedge clk); #1;
         if (reset || !(s_write_enable || s_read_enable)) begin
            busy = 0; s_mem_ready = 1'b0; s_data_out = '0;
         end else begin
            if (busy == 0) begin
               if (mmu_q.size() != 0) cur = mmu_q.pop_front();
               else begin cur.delay = 0; cur.d = '0; end
            end
            busy++;
            s_mem_ready = (cur.delay != 0) && (busy == cur.delay);
            s_data_out  = s_mem_ready ? cur.d : '0;
         end
      end
   end

   // mmu-side monitor: checks each forwarded request when the enables rise.
   initial begin
      logic s_prev, en;
      s_exp_t e;
      s_prev = 1'b0;
      forever begin
         @(negedge clk);
         en = s_write_enable | s_read_enable;
         if (en && !s_prev) begin
            s_start_cyc = cyc;
            if (s_q.size() == 0) fail_now("unexpected_mmu_request");
            else begin
               e = s_q.pop_front();
               check("s_fields", 128'({s_write_enable, s_read_enable, s_signed_read, s_data_width, s_address, s_data_in}),
                     128'({e.we, e.re, e.sg, e.w, e.a, e.d}));
               if (e.chk) check("req_to_enable", 128'(s_start_cyc - assert_cyc[e.m]), 128'(1));
            end
         end
         s_prev = en;
      end
   end

   // Master-side monitor: checks each completion/error pulse against the scoreboard.
   initial begin
      r_exp_t e;
      logic [NM-1:0] oh;
      last_resp_cyc = 0;
      forever begin
         @(negedge clk);
         if (m_mem_ready != '0 || m_error != '0) begin
            resp_seen++;
            for (int i = 0; i < NM; i++) if (m_mem_ready[i]) done[i] = 1'b1;
            if (r_q.size() == 0) fail_now("unexpected_response");
            else begin
               e  = r_q.pop_front();
               oh = NM'(1) << e.m;
               check("ready_owner", 128'(m_mem_ready), 128'(oh));
               check("error_flag", 128'(m_error), 128'(e.err ? oh : 4'b0000));
               check("data_out", 128'(m_data_out), 128'(e.d));
               check("s_enables_low", 128'({s_write_enable, s_read_enable}), 128'(2'b00));
               check("latency", 128'(cyc - s_start_cyc), 128'(e.lat));
               if (e.gap != 0) check("period", 128'(cyc - last_resp_cyc), 128'(e.gap));
            end
            last_resp_cyc = cyc;
         end
      end
   end

   initial begin
      int seen0, n;
      n_checks = 0; n_fail = 0; resp_seen = 0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outputs", 128'({m_data_out, m_mem_ready, m_error, s_write_enable, s_read_enable,
            s_signed_read, s_data_width, s_address, s_data_in}), 128'(0));
      reset = 1'b0;

      // Single read by master 0, mmu answers in its 3rd BUSY cycle.
      mmu(3, 32'hDEADBEEF);
      exp_s(0, 1'b0, 1'b1, 1'b0, 2'b10, 32'h0000_0100, 32'h0, 1'b1);
      exp_r(0, 32'hDEADBEEF, 1'b0, 3, 0);
      enq_req(0, 1'b0, 1'b1, 1'b0, 2'b10, 32'h0000_0100, 32'h0);
      wait_drain(50);

      // Masters 0 and 1 contend with a zero-wait mmu; last owner was 0 so 1 goes first.
      for (int k = 0; k < 3; k++) begin
         enq_req(0, 1'b0, 1'b1, 1'b0, 2'b10, 32'h200 + 32'(4*k), 32'h0);
         enq_req(1, 1'b0, 1'b1, 1'b0, 2'b10, 32'h300 + 32'(4*k), 32'h0);
      end
      for (int j = 0; j < 6; j++) begin
         mmu(1, 32'hA000_0000 + 32'(j));
         exp_s((j % 2 == 0) ? 1 : 0, 1'b0, 1'b1, 1'b0, 2'b10,
               ((j % 2 == 0) ? 32'h300 : 32'h200) + 32'(4*(j/2)), 32'h0, 1'b0);
         exp_r((j % 2 == 0) ? 1 : 0, 32'hA000_0000 + 32'(j), 1'b0, 1, (j == 0) ? 0 : 4);
      end
      wait_drain(100);

      // Timeout: mmu never answers, then answers exactly on the last allowed cycle.
      mmu(0, 32'hFFFF_FFFF);
      exp_s(3, 1'b0, 1'b1, 1'b0, 2'b10, 32'h400, 32'h0, 1'b0);
      exp_r(3, 32'h0, 1'b1, TO, 0);
      enq_req(3, 1'b0, 1'b1, 1'b0, 2'b10, 32'h400, 32'h0);
      wait_drain(50);
      mmu(TO, 32'h1234_5678);
      exp_s(3, 1'b0, 1'b1, 1'b0, 2'b10, 32'h404, 32'h0, 1'b0);
      exp_r(3, 32'h1234_5678, 1'b0, TO, 0);
      enq_req(3, 1'b0, 1'b1, 1'b0, 2'b10, 32'h404, 32'h0);
      wait_drain(50);

      // Both enables on master 2: forwarded as a write only.
      mmu(2, 32'hCAFE_F00D);
      exp_s(2, 1'b1, 1'b0, 1'b0, 2'b10, 32'h480, 32'h55, 1'b0);
      exp_r(2, 32'hCAFE_F00D, 1'b0, 2, 0);
      enq_req(2, 1'b1, 1'b1, 1'b0, 2'b10, 32'h480, 32'h55);
      wait_drain(50);

      // Reset in the middle of a BUSY transaction: request dropped, no completion.
      mmu(0, 32'h0);
      exp_s(0, 1'b1, 1'b0, 1'b0, 2'b10, 32'h500, 32'h77, 1'b0);
      enq_req(0, 1'b1, 1'b0, 1'b0, 2'b10, 32'h500, 32'h77);
      n = 0;
      while (s_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) fail_now("mid_busy_request_not_seen");
      repeat (3) @(negedge clk);
      seen0 = resp_seen;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_mid_busy_outputs", 128'({m_data_out, m_mem_ready, m_error, s_write_enable, s_read_enable,
            s_signed_read, s_data_width, s_address, s_data_in}), 128'(0));
      reset = 1'b0;
      @(negedge clk);
      check("after_reset_outputs", 128'({m_data_out, m_mem_ready, m_error, s_write_enable, s_read_enable,
            s_signed_read, s_data_width, s_address, s_data_in}), 128'(0));
      check("no_ready_through_reset", 128'(resp_seen), 128'(seen0));

      // After reset the scan restarts at master 0, so 1 is served before 3.
      mmu(2, 32'h6161_6161);
      mmu(1, 32'h7373_7373);
      exp_s(1, 1'b0, 1'b1, 1'b0, 2'b10, 32'h600, 32'h0, 1'b0);
      exp_s(3, 1'b0, 1'b1, 1'b1, 2'b01, 32'h700, 32'h0, 1'b0);
      exp_r(1, 32'h6161_6161, 1'b0, 2, 0);
      exp_r(3, 32'h7373_7373, 1'b0, 1, 4);
      enq_req(1, 1'b0, 1'b1, 1'b0, 2'b10, 32'h600, 32'h0);
      enq_req(3, 1'b0, 1'b1, 1'b1, 2'b01, 32'h700, 32'h0);
      wait_drain(60);
      repeat (4) @(negedge clk);
      check("leftover_expectations", 128'(r_q.size() + s_q.size()), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
